// File: rtl/xlr8_float_pkg.sv
// xlr8_float_pkg
// Shared definitions for the floating-point blocks.
//   fdiv_seq_state_t : divide sequencer FSM encoding
//   FDIV_CYCLES      : iteration count of the restoring divide core
package xlr8_float_pkg;

    typedef enum logic [1:0] {
        FDS_IDLE  = 2'd0,
        FDS_START = 2'd1,
        FDS_RUN   = 2'd2,
        FDS_DONE  = 2'd3
    } fdiv_seq_state_t;

    // Clken cycles after start until the core quotient is final.
    localparam int FDIV_CYCLES = 28;

endpackage

// File: rtl/xlr8_fdiv_seq.sv
// xlr8_fdiv_seq
// Operand sequencer and result capture around the FP divide core.
// The core has no valid output, so this block holds the operands stable,
// pulses start, counts the fixed core latency under clken and then
// captures the quotient into a result register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clken               global enable; gates every advance except result handoff
//   abort               synchronous flush back to IDLE, drops a pending result
//   op_valid/op_ready   operand handshake (accept = valid & ready & clken)
//   op_numer/op_denom   operands
//   div_numer/div_denom registered operands to core, stable START..DONE
//   div_start           start pulse to core (asserted while in START)
//   div_q               core quotient (combinational)
//   res_valid/res_ready result handshake toward register-file writeback
//   res_q               captured quotient
//   busy                not IDLE, or waiting out an aborted core run
module xlr8_fdiv_seq
    import xlr8_float_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = FDIV_CYCLES,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clken,
    input  logic              abort,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_numer,
    input  logic [DATA_W-1:0] op_denom,
    output logic [DATA_W-1:0] div_numer,
    output logic [DATA_W-1:0] div_denom,
    output logic              div_start,
    input  logic [DATA_W-1:0] div_q,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_q,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(DIV_CYCLES);

    fdiv_seq_state_t   r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_numer;
    logic [DATA_W-1:0] r_denom;
    logic [DATA_W-1:0] r_res_q;
    logic              w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FDS_IDLE;
            r_cnt   <= '0;
            r_numer <= '0;
            r_denom <= '0;
            r_res_q <= '0;
        end else if (abort) begin
            r_state <= FDS_IDLE;
            // The core keeps iterating after an abort and cannot be restarted
            // until it drains, so reuse the counter as a lockout in IDLE.
            // From DONE the core has already finished; nothing to wait for.
            if (r_state == FDS_START || r_state == FDS_RUN)
                r_cnt <= LP_CNT_LOAD;
        end else begin
            case (r_state)
                FDS_IDLE: begin
                    if (clken) begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (op_valid) begin
                            r_numer <= op_numer;
                            r_denom <= op_denom;
                            r_state <= FDS_START;
                        end
                    end
                end
                FDS_START: begin
                    if (clken) begin
                        r_cnt   <= LP_CNT_LOAD;
                        r_state <= FDS_RUN;
                    end
                end
                FDS_RUN: begin
                    if (clken) begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_res_q <= div_q;
                            r_state <= FDS_DONE;
                        end
                    end
                end
                FDS_DONE: begin
                    // Result handoff is deliberately not gated by clken.
                    if (res_ready)
                        r_state <= FDS_IDLE;
                end
                default: r_state <= FDS_IDLE;
            endcase
        end
    end

    assign op_ready  = (r_state == FDS_IDLE) && w_cnt_zero;
    assign div_start = (r_state == FDS_START);
    assign res_valid = (r_state == FDS_DONE);
    assign busy      = (r_state != FDS_IDLE) || !w_cnt_zero;
    assign div_numer = r_numer;
    assign div_denom = r_denom;
    assign res_q     = r_res_q;

endmodule

// File: tb/tb_xlr8_fdiv_seq.sv
// tb_xlr8_fdiv_seq
// Directed bench for the divide sequencer. A small core stand-in returns a
// table quotient only after DIV_CYCLES clken cycles past start, and junk
// before that, so an early or late capture shows up in res_q.
module tb_xlr8_fdiv_seq;

    localparam int DW  = 32;
    localparam int DIV = 28;

    logic          clk = 1'b0;
    logic          rst_n, clken, abort, op_valid, res_ready;
    logic [DW-1:0] op_numer, op_denom, div_q;
    logic [DW-1:0] div_numer, div_denom, res_q;
    logic          op_ready, div_start, res_valid, busy;

    int tests = 0;
    int fails = 0;

    xlr8_fdiv_seq #(.DATA_W(DW), .DIV_CYCLES(DIV), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_numer(op_numer), .op_denom(op_denom),
        .div_numer(div_numer), .div_denom(div_denom), .div_start(div_start),
        .div_q(div_q), .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core stand-in: iteration counter restarted by start under clken.
    int core_iter;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_iter <= 0;
        else if (clken) begin
            if (div_start)          core_iter <= 0;
            else if (core_iter < DIV) core_iter <= core_iter + 1;
        end
    end

    function automatic logic [DW-1:0] quot(input logic [DW-1:0] n, input logic [DW-1:0] d);
        case ({n, d})
            {32'h40C00000, 32'h40000000}: quot = 32'h40400000;
            {32'h3F800000, 32'h00000000}: quot = 32'h7F800000;
            {32'h00000000, 32'h00000000}: quot = 32'h7FFFFFFF;
            {32'h3F800000, 32'h7F800000}: quot = 32'h00000000;
            {32'h3F800000, 32'h40400000}: quot = 32'h3EAAAAAB;
            {32'hC1200000, 32'h40A00000}: quot = 32'hC0000000;
            default:                      quot = 32'h0BAD0BAD;
        endcase
    endfunction

    always_comb div_q = (core_iter == DIV) ? quot(div_numer, div_denom) : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait for the result; checks latency and value.
    task automatic do_div(input logic [DW-1:0] n, input logic [DW-1:0] d,
                          input logic [DW-1:0] q, input string nm);
        int lat;
        chk({nm, " op_ready"}, op_ready, 1);
        op_valid = 1; op_numer = n; op_denom = d;
        step();
        op_valid = 0; op_numer = 32'h12345678; op_denom = 32'h9ABCDEF0;
        chk({nm, " start"}, {div_start, div_numer, div_denom}, {1'b1, n, d});
        lat = 0;
        while (!res_valid && lat < 200) begin step(); lat++; end
        chk({nm, " latency"}, lat, DIV + 2);
        chk({nm, " res_q"}, res_q, q);
        if (res_ready) begin
            step();
            chk({nm, " one-cycle valid"}, {res_valid, op_ready, busy}, {1'b0, 1'b1, 1'b0});
        end
    endtask

    typedef struct {
        logic [DW-1:0] n;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        string         nm;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   lat, n_edges;
        logic stable, seen_valid;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, "6/2"};
        vecs[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, "1/0"};
        vecs[2] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, "0/0"};
        vecs[3] = '{32'h3F800000, 32'h7F800000, 32'h00000000, "1/inf"};

        rst_n = 0; clken = 1; abort = 0; op_valid = 0; res_ready = 1;
        op_numer = '0; op_denom = '0;
        #12;
        chk("reset outputs", {op_ready, div_start, res_valid, busy, div_numer, div_denom, res_q},
            {1'b1, 1'b0, 1'b0, 1'b0, 96'h0});
        #5 rst_n = 1;
        step();

        // Basic divides and special cases, no stalls
        for (int i = 0; i < 4; i++) do_div(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].nm);

        // clken toggling: accept with clken=1, then 1,0,1,0... from the next edge
        op_valid = 1; op_numer = 32'h3F800000; op_denom = 32'h40400000;
        step();
        op_valid = 0; op_numer = '0; op_denom = '0;
        clken = 1; lat = 0; stable = 1;
        while (!res_valid && lat < 200) begin
            step(); lat++;
            clken = ~clken;
            if (div_numer !== 32'h3F800000 || div_denom !== 32'h40400000) stable = 0;
        end
        clken = 1;
        chk("clken toggle latency", lat, 59);
        chk("clken toggle res_q", res_q, 32'h3EAAAAAB);
        chk("clken toggle operands stable", stable, 1);
        step();

        // Result back-pressure: held 10 cycles, new op ignored
        res_ready = 0;
        do_div(32'h40C00000, 32'h40000000, 32'h40400000, "backpressure");
        op_valid = 1; op_numer = 32'hC1200000; op_denom = 32'h40A00000;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!res_valid || res_q !== 32'h40400000 || op_ready || div_numer !== 32'h40C00000) stable = 0;
        end
        chk("hold while res_ready low", stable, 1);
        op_valid = 0; res_ready = 1;
        step();
        chk("release to IDLE", {res_valid, op_ready}, {1'b0, 1'b1});
        do_div(32'h3F800000, 32'h00000000, 32'h7F800000, "after release");

        // abort and res_ready together in DONE: abort wins, no lockout
        res_ready = 0;
        do_div(32'h00000000, 32'h00000000, 32'h7FFFFFFF, "pre-abort done");
        abort = 1; res_ready = 1;
        step();
        abort = 0;
        chk("abort in DONE", {res_valid, op_ready, busy}, {1'b0, 1'b1, 1'b0});

        // abort with op_valid in IDLE: no accept
        abort = 1; op_valid = 1; op_numer = 32'h40C00000; op_denom = 32'h40000000;
        step();
        abort = 0; op_valid = 0;
        chk("abort beats op_valid", {busy, div_start, op_ready}, {1'b0, 1'b0, 1'b1});

        // abort in RUN at cnt=10 with clken low on the abort edge
        op_valid = 1; op_numer = 32'h3F800000; op_denom = 32'h40400000;
        step();
        op_valid = 0;
        for (int i = 0; i < 19; i++) step();
        abort = 1; clken = 0;
        step();
        abort = 0; clken = 1;
        chk("abort to IDLE", {res_valid, op_ready, busy, div_start}, {1'b0, 1'b0, 1'b1, 1'b0});
        n_edges = 1; seen_valid = 0;
        while (!op_ready && n_edges < 100) begin
            step(); n_edges++;
            if (res_valid) seen_valid = 1;
        end
        chk("abort lockout length", n_edges, DIV + 1);
        chk("no result after abort", seen_valid, 0);
        do_div(32'hC1200000, 32'h40A00000, 32'hC0000000, "after abort");

        // Asynchronous reset mid-RUN, off the clock edge
        op_valid = 1; op_numer = 32'h40C00000; op_denom = 32'h40000000;
        step();
        op_valid = 0;
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 0;
        #1;
        chk("async reset mid-run", {op_ready, div_start, res_valid, busy, div_numer, div_denom, res_q},
            {1'b1, 1'b0, 1'b0, 1'b0, 96'h0});
        #2 rst_n = 1;
        step();
        do_div(32'h40C00000, 32'h40000000, 32'h40400000, "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
